// File: rtl/matrix_result_streamer_if.sv
// rtl/matrix_result_streamer_if.sv - word stream interface between the result streamer and its consumer
interface matrix_result_streamer_if #(
    parameter int ELEM_WIDTH = 32
);
    logic [ELEM_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - snapshots VALU result vectors on done rise and streams them as words
// Optional trailing XOR checksum beat: MATRIX_RESULT_CHECKSUM_EN
module matrix_result_streamer #(
    parameter  int ELEM_WIDTH = 32,
    parameter  int VEC_COUNT  = 4,
    localparam int VLEN       = ELEM_WIDTH * VEC_COUNT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      done_in,
    input  logic [VLEN-1:0]           result_in [VEC_COUNT],
    matrix_result_streamer_if.master  stream,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
);
    localparam int WORDS_PER_VEC = VLEN / ELEM_WIDTH;
    localparam int DATA_BEATS    = VEC_COUNT * WORDS_PER_VEC;
`ifdef MATRIX_RESULT_CHECKSUM_EN
    localparam int NUM_BEATS     = DATA_BEATS + 1;
`else
    localparam int NUM_BEATS     = DATA_BEATS;
`endif
    localparam int AW            = $clog2(NUM_BEATS);
    localparam logic [4:0] LAST_IDX = 5'(NUM_BEATS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state;
    logic [4:0]            idx;
    logic                  done_q;
    logic                  done_rise;
    logic [ELEM_WIDTH-1:0] snap [NUM_BEATS];
    logic [ELEM_WIDTH-1:0] cap  [NUM_BEATS];
    logic [AW-1:0]         nxt_a;

    assign done_rise = done_in & ~done_q;
    assign nxt_a     = AW'(idx + 5'd1);

    // Capture image in beat order: beat v*WORDS_PER_VEC+e is vector v, element e
`ifdef MATRIX_RESULT_CHECKSUM_EN
    logic [ELEM_WIDTH-1:0] csum;

    always_comb begin
        csum = '0;
        for (int v = 0; v < VEC_COUNT; v++) begin
            for (int e = 0; e < WORDS_PER_VEC; e++) begin
                cap[v*WORDS_PER_VEC+e] = result_in[v][e*ELEM_WIDTH +: ELEM_WIDTH];
                csum = csum ^ result_in[v][e*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
        cap[DATA_BEATS] = csum;
    end
`else
    always_comb begin
        for (int v = 0; v < VEC_COUNT; v++) begin
            for (int e = 0; e < WORDS_PER_VEC; e++) begin
                cap[v*WORDS_PER_VEC+e] = result_in[v][e*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            idx              <= '0;
            done_q           <= 1'b0;
            for (int i = 0; i < NUM_BEATS; i++) snap[i] <= '0;
            stream.out_data  <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            done_q     <= done_in;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (done_rise) begin
                        snap             <= cap;
                        idx              <= '0;
                        stream.out_data  <= cap[0];
                        stream.out_valid <= 1'b1;
                        stream.out_last  <= 1'b0;
                        busy             <= 1'b1;
                        state            <= STREAM;
                    end
                end
                STREAM: begin
                    // A rise while streaming is dropped, including on the final-beat edge
                    if (done_rise) overrun <= 1'b1;
                    if (stream.out_valid && stream.out_ready) begin
                        if (idx == LAST_IDX) begin
                            stream.out_data  <= '0;
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                            busy             <= 1'b0;
                            frame_done       <= 1'b1;
                            state            <= IDLE;
                        end else begin
                            idx             <= idx + 5'd1;
                            stream.out_data <= snap[nxt_a];
                            stream.out_last <= ((idx + 5'd1) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb/tb_matrix_result_streamer.sv - directed self-checking bench for matrix_result_streamer
module tb_matrix_result_streamer;
`ifdef MATRIX_RESULT_CHECKSUM_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         done_in;
    logic [127:0] result_in [4];
    logic         busy;
    logic         frame_done;
    logic         overrun;
    logic [31:0]  exp_w [17];
    int           checks = 0;
    int           errors = 0;
    int           nb;
    int           cnt;

    matrix_result_streamer_if #(.ELEM_WIDTH(32)) sif ();

    matrix_result_streamer #(.ELEM_WIDTH(32), .VEC_COUNT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .done_in    (done_in),
        .result_in  (result_in),
        .stream     (sif.master),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // word e of vector v = 32'h{v}{e}00_00AA; XOR of all sixteen cancels to 0
    task automatic set_pattern_a();
        for (int v = 0; v < 4; v++)
            for (int e = 0; e < 4; e++) begin
                result_in[v][e*32 +: 32] = (32'(v) << 28) | (32'(e) << 24) | 32'h0000_00AA;
                exp_w[v*4+e] = (32'(v) << 28) | (32'(e) << 24) | 32'h0000_00AA;
            end
        exp_w[16] = 32'h0000_0000;
    endtask

    // words 1..16 in beat order; XOR of 1..16 is 16
    task automatic set_pattern_count();
        for (int k = 0; k < 16; k++) begin
            result_in[k/4][(k%4)*32 +: 32] = 32'(k + 1);
            exp_w[k] = 32'(k + 1);
        end
        exp_w[16] = 32'h0000_0010;
    endtask

    task automatic run_frame(input int mode, input bit drop_done, input int rise_at,
                             input int abort_at, output int nbeats);
        int          cyc;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        bit          pend;
        bit          risen;
        bit          rise_flag;
        bit          fin;
        logic        rdy;
        nbeats = 0; cyc = 0; prev_stall = 0; pend = 0; risen = 0; rise_flag = 0; fin = 0;
        prev_data = '0; prev_last = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (drop_done && cyc == 0) done_in = 1'b0;
            if (rise_flag) begin
                done_in = 1'b0;
                rise_flag = 0;
            end
            if (pend) begin
                check("frame_done_pulse", 32'(frame_done), 32'd1);
                check("valid_after_frame", 32'(sif.out_valid), 32'd0);
                fin = 1;
            end else if (abort_at == nbeats) begin
                reset_n = 1'b0;
                #1;
                check("rst_data", sif.out_data, 32'd0);
                check("rst_valid", 32'(sif.out_valid), 32'd0);
                check("rst_last", 32'(sif.out_last), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_frame_done", 32'(frame_done), 32'd0);
                check("rst_overrun", 32'(overrun), 32'd0);
                fin = 1;
            end else begin
                if (prev_stall) begin
                    check("hold_data", sif.out_data, prev_data);
                    check("hold_last", 32'(sif.out_last), 32'(prev_last));
                end
                check("valid_in_frame", 32'(sif.out_valid), 32'd1);
                if (rise_at == nbeats && !risen) begin
                    for (int v = 0; v < 4; v++) result_in[v] = {128{1'b1}};
                    done_in = 1'b1;
                    risen = 1;
                    rise_flag = 1;
                end
                rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
                sif.out_ready = rdy;
                if (rdy) begin
                    check($sformatf("beat%0d_data", nbeats), sif.out_data, exp_w[nbeats]);
                    check($sformatf("beat%0d_last", nbeats), 32'(sif.out_last),
                          32'(nbeats == NB - 1));
                    nbeats++;
                    if (nbeats == NB) pend = 1;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_data = sif.out_data;
                    prev_last = sif.out_last;
                end
            end
            cyc++;
            if (!fin && cyc > 200) begin
                check("frame_timeout", 32'(cyc), 32'd0);
                fin = 1;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        done_in = 1'b0;
        sif.out_ready = 1'b0;
        for (int v = 0; v < 4; v++) result_in[v] = '0;
        repeat (3) @(negedge clk);
        check("reset_data", sif.out_data, 32'd0);
        check("reset_valid", 32'(sif.out_valid), 32'd0);
        check("reset_last", 32'(sif.out_last), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;

        // plain frame, consumer always ready
        @(negedge clk);
        set_pattern_a();
        done_in = 1'b1;
        run_frame(0, 1, -1, -1, nb);
        check("frame1_beats", 32'(nb), 32'(NB));
        check("frame1_overrun", 32'(overrun), 32'd0);

        // back-pressure with ready 1,0,0 repeating
        @(negedge clk);
        set_pattern_a();
        done_in = 1'b1;
        run_frame(1, 1, -1, -1, nb);
        check("stall_beats", 32'(nb), 32'(NB));
        sif.out_ready = 1'b1;

        // done held high for 40 cycles yields one frame only
        @(negedge clk);
        set_pattern_a();
        done_in = 1'b1;
        run_frame(0, 0, -1, -1, nb);
        check("held_beats", 32'(nb), 32'(NB));
        cnt = 0;
        repeat (40 - NB - 1) begin
            @(negedge clk);
            if (busy || sif.out_valid) cnt++;
        end
        check("held_no_refire", 32'(cnt), 32'd0);
        done_in = 1'b0;
        @(negedge clk);
        check("held_overrun", 32'(overrun), 32'd0);

        // rise during beat 7 with all-ones data is dropped and flagged
        set_pattern_a();
        done_in = 1'b1;
        run_frame(0, 1, 7, -1, nb);
        check("overrun_beats", 32'(nb), 32'(NB));
        check("overrun_set", 32'(overrun), 32'd1);
        repeat (5) @(negedge clk);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("overrun_no_frame", 32'(busy), 32'd0);

        // asynchronous reset at beat 9 discards the frame
        set_pattern_a();
        done_in = 1'b1;
        run_frame(0, 1, -1, 9, nb);
        check("abort_at_beat", 32'(nb), 32'd9);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || sif.out_valid) cnt++;
        end
        check("post_reset_idle", 32'(cnt), 32'd0);
        set_pattern_a();
        done_in = 1'b1;
        run_frame(0, 1, -1, -1, nb);
        check("post_reset_beats", 32'(nb), 32'(NB));

`ifdef MATRIX_RESULT_CHECKSUM_EN
        @(negedge clk);
        set_pattern_count();
        done_in = 1'b1;
        run_frame(0, 1, -1, -1, nb);
        check("checksum_beats", 32'(nb), 32'd17);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_result_streamer.md
# matrix_result_streamer

- Sits directly downstream of the vector compute system.
- On each rising edge of the compute `done` flag it snapshots the four 128-bit result vectors.
- It then streams the snapshot out as 32-bit words over a valid/ready handshake, with a last-beat marker.
- This decouples the combinational VALU result from a narrow, back-pressured consumer such as a UART/AXI-stream bridge or a test sink.

## Interface
Parameters:
- `ELEM_WIDTH`, 32, element/output word width in bits
- `VEC_COUNT`, 4, number of result vectors
- `VLEN`, `ELEM_WIDTH*VEC_COUNT` (128), bits per vector; derived, not overridden

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `done_in`  in  1  compute-complete level from the upstream FSM
- `result_in`  in  `[VLEN-1:0]` x `[VEC_COUNT]`  result vectors, unpacked array, valid while `done_in`=1
- `out_data`  out  `ELEM_WIDTH`  current stream word
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts the word
- `out_last`  out  1  marks the final beat of a frame
- `busy`  out  1  a frame is being streamed
- `frame_done`  out  1  one-cycle pulse after the final beat is accepted
- `overrun`  out  1  sticky; a `done_in` rise was dropped

## Operation
- Edge detection:
  - `done_q` is a register of `done_in`; `done_rise = done_in & ~done_q`.
  - `done_q` resets to 0, so `done_in`=1 on the first cycle after reset counts as a rise.
- FSM with two states, IDLE and STREAM:
  - IDLE: if `done_rise`, load the snapshot from `result_in[0..VEC_COUNT-1]`, clear the word index, go to STREAM.
  - STREAM: a beat transfers on a clock edge where `out_valid & out_ready`; the index then increments.
  - STREAM exit: when the final beat transfers, go to IDLE and pulse `frame_done`.
- Word order: index k = v*4 + e, giving `out_data = snapshot[v][e*32 +: 32]`.
  - Beat 0 is vector 0, bits [31:0]; beat 15 is vector 3, bits [127:96].
  - The frame is 16 beats (`VEC_COUNT*VLEN/ELEM_WIDTH`). The index is 5 bits and never wraps within a frame.
- Output signals:
  - `out_valid` = 1 throughout STREAM.
  - `out_last` = 1 only while the index equals the final beat.
  - `busy` = state==STREAM.
- Overrun:
  - A `done_rise` during STREAM sets `overrun`. This includes the edge on which the final beat transfers.
  - The snapshot and the frame in flight are unaffected.
  - `overrun` clears only on reset.
- Held `done_in`: a level held high for many cycles produces exactly one capture.
- Reset mid-frame:
  - Everything clears immediately: state IDLE, index 0, snapshot 0, `out_valid`/`out_last`/`busy`/`frame_done`/`overrun` all 0.
  - The partial frame is discarded; there is no resume.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `frame_done`=0, `overrun`=0.
- Latency: if `done_rise` is sampled at edge N, then `out_valid`, `busy` and `out_data`=beat 0 are all visible after edge N.
- With `out_ready` tied high, the frame occupies 16 consecutive cycles. `frame_done` is high for the cycle after the edge that accepts the final beat, and `out_valid`=0 in that cycle.
- Hold rule: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable. `out_valid` never drops mid-frame.
- Minimum spacing: a rise accepted earliest is on the edge after the one where IDLE is re-entered. That gives back-to-back frames with a one-cycle bubble.
- All outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` to any output.

## Configuration
- `MATRIX_RESULT_CHECKSUM_EN`:
  - Defined: a 17th beat follows beat 15. It carries the XOR of all 16 snapshot words, computed at capture time. `out_last` moves to this beat, and `frame_done` follows its acceptance.
  - Undefined: the frame is 16 beats, `out_last` is on beat 15, and no checksum logic is built.

## Test plan
- Reset, then a `done_in` rise with `result_in[v]` word e = 32'h{v}{e}00_00AA; `out_ready`=1 → 16 beats in order, beat 0 = 32'h0000_00AA, beat 15 = 32'h3300_00AA, `out_last` only on beat 15, `frame_done` one cycle after.
- Same stimulus with `out_ready` toggling 1,0,0,1,… → no beat lost or repeated; `out_data` stable while stalled; 16 accepted beats total.
- `done_in` held high for 40 cycles → exactly one frame, `overrun`=0.
- Second `done_in` rise at beat 7, new data all 32'hFFFF_FFFF → original frame completes unchanged; `overrun`=1 and stays 1 until `reset_n`=0.
- Assert `reset_n`=0 asynchronously at beat 9 → all outputs 0 immediately; after release with `done_in`=0 no frame starts; a fresh rise streams from beat 0.
- With `MATRIX_RESULT_CHECKSUM_EN` and words 32'h1..32'h10 → 17 beats; beat 16 = 32'h0000_0010 (XOR of 1..16) with `out_last`=1.
